// File: rtl/feeder_pkg.sv
// Shared types and constants for the array west-edge feeder.
package feeder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StGap,
    StExec,
    StDrain
  } state_e;

  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_EXEC   = 2'b10;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  // Number of bits needed to hold the value v.
  function automatic int unsigned bits_for(input int unsigned v);
    for (int unsigned i = 1; i < 32; i++) begin
      if ((v >> i) == 0) return i;
    end
    return 32;
  endfunction

  // The beat/drain counter must hold a full execute length, a mode-1 load and a drain count.
  function automatic int unsigned cnt_width(input int unsigned len_bw, input int unsigned col,
                                            input int unsigned row);
    int unsigned w;
    w = len_bw;
    if (bits_for(2 * col) > w) w = bits_for(2 * col);
    if (bits_for(row) > w) w = bits_for(row);
    return w;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-depth register delay line with synchronous clear; depth 0 degenerates to a wire.
module skew_line #(
  parameter int unsigned depth = 1,
  parameter int unsigned width = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);

  if (depth == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign q_o = d_i;
  end else begin : g_line
    logic [width-1:0] line_q [depth];
    logic [width-1:0] line_d [depth];

    always_comb begin
      line_d[0] = d_i;
      for (int unsigned i = 1; i < depth; i++) begin
        line_d[i] = line_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned i = 0; i < depth; i++) begin
          line_q[i] <= '0;
        end
      end else begin
        line_q <= line_d;
      end
    end

    assign q_o = line_q[depth-1];
  end

endmodule

// File: rtl/array_west_feeder.sv
// West-edge feeder for the systolic MAC array: sequences kernel loads and executes onto in_w/inst_w.
// Define FEEDER_SKEW_EN to build per-row diagonal skew lines; otherwise upstream pre-skews.
module array_west_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned bw     = 4,
  parameter int unsigned row    = 8,
  parameter int unsigned col    = 8,
  parameter int unsigned len_bw = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic [1:0]          cmd_op,
  input  logic [len_bw-1:0]   cmd_len,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [row*bw-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [row*bw-1:0]   out_w,
  output logic [2*row-1:0]    out_inst,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned CntW = cnt_width(len_bw, col, row);
`ifdef FEEDER_SKEW_EN
  localparam int unsigned SkewEn      = 1;
  localparam int unsigned DrainCycles = (row > 1) ? row - 1 : 1;
`else
  localparam int unsigned SkewEn      = 0;
  localparam int unsigned DrainCycles = 1;
`endif
  localparam logic [CntW-1:0] DrainInit  = CntW'(DrainCycles - 1);
  localparam logic [CntW-1:0] LoadBeats0 = CntW'(col);
  localparam logic [CntW-1:0] LoadBeats1 = CntW'(2 * col);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [1:0]          inst_q, inst_d;
  logic [row*bw-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                xfer;

  assign cmd_ready = (state_q == StIdle) & ~reset;
  assign in_ready  = ((state_q == StLoad) | (state_q == StExec)) & ~reset;
  assign xfer      = in_valid & in_ready;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst_d  = INST_IDLE;
    data_d  = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          unique case (cmd_op)
            OP_LOAD: begin
              state_d = StLoad;
              cnt_d   = mode ? LoadBeats1 : LoadBeats0;
            end
            OP_EXEC: begin
              if (cmd_len == '0) begin
                state_d = StDrain;
                cnt_d   = DrainInit;
              end else begin
                state_d = StExec;
                cnt_d   = CntW'(cmd_len);
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StLoad, StExec: begin
        if (xfer) begin
          inst_d = (state_q == StLoad) ? INST_LOAD : INST_EXEC;
          data_d = in_data;
          cnt_d  = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = (state_q == StLoad) ? StGap : StDrain;
            cnt_d   = DrainInit;
          end
        end
      end
      StGap: begin
        state_d = StDrain;
        cnt_d   = DrainInit;
      end
      StDrain: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      inst_q  <= INST_IDLE;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Row r sees the row-0 {inst, data} word r cycles later (or immediately without skew).
  for (genvar r = 0; r < row; r++) begin : g_row
    logic [bw+1:0] line_q;

    skew_line #(
      .depth(SkewEn * r),
      .width(bw + 2)
    ) u_skew (
      .clk  (clk),
      .reset(reset),
      .d_i  ({inst_q, data_q[r*bw +: bw]}),
      .q_o  (line_q)
    );

    assign out_w[r*bw +: bw]  = line_q[bw-1:0];
    assign out_inst[2*r +: 2] = line_q[bw+1:bw];
  end

endmodule

// File: tb/tb_array_west_feeder.sv
// Self-checking bench for array_west_feeder: timeline model of expected outputs plus literal checks.
module tb_array_west_feeder;

  localparam int Bw     = 4;
  localparam int Row    = 8;
  localparam int Col    = 8;
  localparam int LenBw  = 8;
  localparam int MaxCyc = 1024;
`ifdef FEEDER_SKEW_EN
  localparam int SkewOn = 1;
  localparam int Drain  = Row - 1;
`else
  localparam int SkewOn = 0;
  localparam int Drain  = 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              mode;
  logic [1:0]        cmd_op;
  logic [LenBw-1:0]  cmd_len;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [Row*Bw-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [Row*Bw-1:0] out_w;
  logic [2*Row-1:0]  out_inst;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  array_west_feeder #(
    .bw    (Bw),
    .row   (Row),
    .col   (Col),
    .len_bw(LenBw)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .cmd_op   (cmd_op),
    .cmd_len  (cmd_len),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_w    (out_w),
    .out_inst (out_inst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int last_rst = -1;
  bit chk_on = 0;

  // Expected row-0 stream and control outputs, indexed by cycle.
  logic [1:0]        exp_inst0 [MaxCyc];
  logic [Row*Bw-1:0] exp_data  [MaxCyc];
  bit exp_ir [MaxCyc], exp_cr [MaxCyc], exp_busy [MaxCyc], exp_done [MaxCyc], exp_err [MaxCyc];
  bit rst_flag [MaxCyc];

  // Observed values, for the literal checks.
  logic [1:0]    obs_inst0 [MaxCyc];
  logic [1:0]    obs_row3  [MaxCyc];
  logic [Bw-1:0] obs_d0    [MaxCyc];
  logic obs_ir [MaxCyc], obs_cr [MaxCyc], obs_busy [MaxCyc], obs_done [MaxCyc], obs_err [MaxCyc];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MaxCyc - 64) begin
      $display("FAIL cycle_budget cyc=%0d got=overrun want=below_%0d", cyc, MaxCyc - 64);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic set_idle(input int from);
    for (int m = from; m < MaxCyc; m++) begin
      exp_inst0[m] = 2'b00;
      exp_data[m]  = '0;
      exp_ir[m]    = 1'b0;
      exp_cr[m]    = 1'b1;
      exp_busy[m]  = 1'b0;
      exp_done[m]  = 1'b0;
      exp_err[m]   = 1'b0;
    end
  endtask

  function automatic logic [Row*Bw-1:0] fill(input logic [Bw-1:0] nib);
    logic [Row*Bw-1:0] w;
    for (int r = 0; r < Row; r++) w[r*Bw +: Bw] = nib;
    return w;
  endfunction

  function automatic logic [Row*Bw-1:0] rnd_word();
    logic [Row*Bw-1:0] w;
    for (int r = 0; r < Row; r++) w[r*Bw +: Bw] = Bw'($urandom);
    return w;
  endfunction

  // sel: 0 in_ready, 1 done, 2 err, 3 busy, 4 row3 load, 5 row0 load
  function automatic bit obs_hit(input int sel, input int i);
    case (sel)
      0: return obs_ir[i] === 1'b1;
      1: return obs_done[i] === 1'b1;
      2: return obs_err[i] === 1'b1;
      3: return obs_busy[i] === 1'b1;
      4: return obs_row3[i] === 2'b01;
      default: return obs_inst0[i] === 2'b01;
    endcase
  endfunction

  function automatic int cnt(input int sel, input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++) if (obs_hit(sel, i)) s++;
    return s;
  endfunction

  function automatic int first_hit(input int sel, input int a);
    for (int i = a; i < cyc; i++) if (obs_hit(sel, i)) return i;
    return -1;
  endfunction

  // Drive one command and write the expected timeline it implies.
  task automatic do_cmd(input logic [1:0] op, input int len, input bit md, input int kind,
                        input logic [31:0] bub, input int abort_at,
                        output int c, output int tf, output int tl, output int d);
    int nb, n, k, off;
    bit v, isl;
    logic [Row*Bw-1:0] w;
    c = cyc; tf = -1; tl = cyc; d = -1;
    cmd_valid = 1'b1; cmd_op = op; cmd_len = LenBw'(len); mode = md;
    if (op != 2'b01 && op != 2'b10) begin
      exp_err[c+1] = 1'b1;
      step();
      cmd_valid = 1'b0;
      step();
      return;
    end
    isl = (op == 2'b01);
    nb = isl ? (md ? 2 * Col : Col) : len;
    step();
    cmd_valid = 1'b0; mode = ~md; cmd_len = LenBw'($urandom);
    k = 0;
    while (k < nb) begin
      n = cyc;
      if (k == abort_at) begin
        in_valid = 1'b0; reset = 1'b1; rst_flag[n] = 1'b1;
        set_idle(n + 1);
        step();
        reset = 1'b0;
        step();
        return;
      end
      off = n - c - 1;
      v = (off < 32) ? !bub[off] : 1'b1;
      w = (kind == 1) ? fill((k % 2 == 0) ? 4'h3 : 4'hC) : rnd_word();
      exp_ir[n] = 1'b1; exp_busy[n] = 1'b1; exp_cr[n] = 1'b0;
      in_valid = v;
      in_data = v ? w : rnd_word();
      if (v) begin
        exp_inst0[n+1] = isl ? 2'b01 : 2'b10;
        exp_data[n+1]  = w;
        if (k == 0) tf = n;
        tl = n;
        k++;
      end
      step();
    end
    d = isl ? tl + 2 + Drain : tl + 1 + Drain;
    exp_done[d] = 1'b1;
    while (cyc < d) begin
      exp_busy[cyc] = 1'b1; exp_cr[cyc] = 1'b0;
      in_valid = 1'b1; in_data = rnd_word(); cmd_valid = 1'b1; cmd_op = 2'b10;
      step();
    end
    in_valid = 1'b0; cmd_valid = 1'b0; in_data = '0;
    step();
  endtask

  // Per-cycle comparison against the timeline model.
  always @(negedge clk) begin
    int n, src;
    bit skip, rst;
    logic [Row*Bw-1:0] ew;
    logic [2*Row-1:0] ei;
    n = cyc;
    obs_inst0[n] = out_inst[1:0];
    obs_row3[n]  = out_inst[7:6];
    obs_d0[n]    = out_w[Bw-1:0];
    obs_ir[n] = in_ready; obs_cr[n] = cmd_ready; obs_busy[n] = busy;
    obs_done[n] = done; obs_err[n] = err;
    rst = rst_flag[n];
    skip = 1'b0;
    if (rst) begin
      if (n == 0) skip = 1'b1;
      else if (!rst_flag[n-1]) skip = 1'b1;
    end
    if (chk_on && !skip) begin
      ew = '0;
      ei = '0;
      if (!rst) begin
        for (int r = 0; r < Row; r++) begin
          src = n - r * SkewOn;
          if (src > last_rst && src >= 0) begin
            ew[r*Bw +: Bw] = exp_data[src][r*Bw +: Bw];
            ei[2*r +: 2]   = exp_inst0[src];
          end
        end
      end
      chk("out_w", 64'(out_w), 64'(ew));
      chk("out_inst", 64'(out_inst), 64'(ei));
      chk("in_ready", 64'(in_ready), 64'(rst ? 1'b0 : exp_ir[n]));
      chk("cmd_ready", 64'(cmd_ready), 64'(rst ? 1'b0 : exp_cr[n]));
      chk("busy", 64'(busy), 64'(rst ? 1'b0 : exp_busy[n]));
      chk("done", 64'(done), 64'(rst ? 1'b0 : exp_done[n]));
      chk("err", 64'(err), 64'(rst ? 1'b0 : exp_err[n]));
    end
    if (rst) last_rst = n;
  end

  initial begin
    int c, tf, tl, d, f;
    logic [63:0] cap;
    logic [9:0] pk;
    set_idle(0);
    for (int i = 0; i < MaxCyc; i++) rst_flag[i] = 1'b0;
    for (int i = 0; i < 5; i++) rst_flag[i] = 1'b1;
    reset = 1'b1; cmd_valid = 1'b0; in_valid = 1'b0; cmd_op = 2'b00;
    cmd_len = '0; mode = 1'b0; in_data = '0;
    chk_on = 1'b1;
    repeat (5) step();
    reset = 1'b0;
    step();
    step();
    chk("rst_cmd_ready", 64'(obs_cr[4]), 64'(0));
    chk("rel_cmd_ready", 64'(obs_cr[5]), 64'(1));
    chk("rel_busy", 64'(obs_busy[5]), 64'(0));
    chk("rel_inst0", 64'(obs_inst0[5]), 64'(0));

    // Mode 0 load, continuous valid.
    do_cmd(2'b01, 0, 1'b0, 0, 32'h0, -1, c, tf, tl, d);
    chk("ld0_ir_beats", 64'(cnt(0, c, d)), 64'(8));
    chk("ld0_span", 64'(tl - tf), 64'(7));
    chk("ld0_row3_beats", 64'(cnt(4, c, d)), 64'(8));
    f = first_hit(4, c);
    chk("ld0_row3_first", 64'(f - tf), 64'(SkewOn ? 4 : 1));
    f = first_hit(1, c);
    chk("ld0_done_lat", 64'(f - tl), 64'(SkewOn ? 9 : 3));

    // Mode 1 load: 3 then C per tile.
    do_cmd(2'b01, 0, 1'b1, 1, 32'h0, -1, c, tf, tl, d);
    chk("ld1_row0_beats", 64'(cnt(5, c, d)), 64'(16));
    cap = '0;
    for (int i = c; i <= d; i++) if (obs_inst0[i] === 2'b01) cap = {cap[59:0], obs_d0[i]};
    chk("ld1_nibbles", cap, 64'h3C3C_3C3C_3C3C_3C3C);

    // Execute len=4 with a bubble on the 2nd cycle.
    do_cmd(2'b10, 4, 1'b0, 0, 32'h2, -1, c, tf, tl, d);
    pk = {obs_inst0[c+2], obs_inst0[c+3], obs_inst0[c+4], obs_inst0[c+5], obs_inst0[c+6]};
    chk("ex4_row0_inst", 64'(pk), 64'(10'b10_00_10_10_10));
    chk("ex4_last_beat", 64'(tl - c), 64'(5));
    f = first_hit(1, c);
    chk("ex4_done_lat", 64'(f - tl), 64'(SkewOn ? 8 : 2));

    // Execute len=0 goes straight to drain.
    do_cmd(2'b10, 0, 1'b0, 0, 32'h0, -1, c, tf, tl, d);
    chk("ex0_ir", 64'(cnt(0, c, d)), 64'(0));
    f = first_hit(1, c);
    chk("ex0_done_lat", 64'(f - c), 64'(SkewOn ? 8 : 2));

    // Illegal opcodes.
    do_cmd(2'b11, 0, 1'b0, 0, 32'h0, -1, c, tf, tl, d);
    chk("ill11_err", 64'(cnt(2, c, c + 1)), 64'(1));
    chk("ill11_err_at", 64'(obs_err[c+1]), 64'(1));
    chk("ill11_busy", 64'(cnt(3, c, c + 1)), 64'(0));
    do_cmd(2'b00, 0, 1'b1, 0, 32'h0, -1, c, tf, tl, d);
    chk("ill00_err", 64'(cnt(2, c, c + 1)), 64'(1));

    // Reset mid-execute after 2 beats, then a normal load.
    do_cmd(2'b10, 4, 1'b0, 0, 32'h0, 2, c, tf, tl, d);
    chk("abort_ir", 64'(cnt(0, c, cyc - 1)), 64'(2));
    chk("abort_no_done", 64'(cnt(1, c, cyc - 1)), 64'(0));
    do_cmd(2'b01, 0, 1'b0, 0, 32'h5, -1, c, tf, tl, d);
    chk("post_abort_done", 64'(cnt(1, c, d)), 64'(1));

    // Execute with scattered bubbles.
    do_cmd(2'b10, 6, 1'b1, 0, 32'h2D, -1, c, tf, tl, d);
    f = first_hit(1, c);
    chk("ex6_done_lat", 64'(f - tl), 64'(SkewOn ? 8 : 2));

    repeat (Row + 2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
